// File: rtl/arith_pkg.sv
// ============================================================================
// Module : arith_pkg
// Brief  : Shared op codes, request word layout and issue FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam int REQ_W = 7;

  // Request word layout {sel, cin, b, a}
  typedef struct packed {
    logic [1:0] sel;
    logic       cin;
    logic [1:0] b;
    logic [1:0] a;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/arith_op_fifo.sv
// ============================================================================
// Module : arith_op_fifo
// Brief  : DEPTH-entry request FIFO; push gated internally by full, pop by empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arith_op_fifo
  import arith_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  req_t wr_data,
  output req_t rd_data,
  output logic full,
  output logic empty
);

  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arith_issue_stage.sv
// ============================================================================
// Module : arith_issue_stage
// Brief  : Queues ALU requests, issues one at a time, holds result on valid/ready.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arith_issue_stage
  import arith_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_sel,
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_s,
  input  logic [3:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [1:0]       res_sel,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_d;
  req_t             op_q, op_d;
  logic [3:0]       res_data_q, res_data_d;
  logic [1:0]       res_sel_q, res_sel_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  req_t             fifo_head;
  req_t             fifo_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign fifo_wr = '{sel: in_sel, cin: in_cin, b: in_b, a: in_a};

  arith_op_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready  = ~fifo_full;
  assign alu_a     = op_q.a;
  assign alu_b     = op_q.b;
  assign alu_cin   = op_q.cin;
  assign alu_s     = op_q.sel;
  assign res_valid = (state_q == ST_HOLD);
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign op_count  = op_count_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_sel_d  = res_sel_q;
    op_count_d = op_count_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Operands have been stable a full cycle, so alu_out is settled
        res_data_d = alu_out;
        res_sel_d  = op_q.sel;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            op_d     = fifo_head;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      res_data_q <= '0;
      res_sel_q  <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_sel_q  <= res_sel_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_issue_stage.sv
// ============================================================================
// Module : tb_arith_issue_stage
// Brief  : Directed bench for arith_issue_stage driving a 2-bit ALU model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arith_issue_stage;
  import arith_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a, in_b, in_sel;
  logic       in_cin;
  logic [1:0] alu_a, alu_b, alu_s;
  logic       alu_cin;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_sel;
  logic [7:0] op_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arith_issue_stage #(
    .DEPTH (4),
    .AW    (2),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sel   (res_sel),
    .op_count  (op_count)
  );

  function automatic logic [3:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic cin, input logic [1:0] sel);
    logic [2:0] s3;
    s3 = 3'(a) + 3'(b) + 3'(cin);
    case (sel)
      OP_PASS: return {2'b00, a};
      OP_NAND: return {2'b00, ~(a & b)};
      OP_ADD:  return {1'b0, s3};
      default: return 4'(a) * 4'(b);
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_cin, alu_s);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] a, input logic [1:0] b,
                          input logic cin, input logic [1:0] sel);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sel   = sel;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("res_valid_timeout", 32'(res_valid), 1);
  endtask

  // Stall-test vectors and hand-computed ALU results
  logic [1:0] ta [5] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd3};
  logic [1:0] tb [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd3};
  logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] ts [5] = '{OP_ADD, OP_MUL, OP_NAND, OP_PASS, OP_ADD};
  logic [3:0] te [5] = '{4'd2, 4'd6, 4'd3, 4'd3, 4'd7};

  logic [3:0] exp_q [$];
  int n, acc, k, stale, pushed, handed;
  logic do_push, do_hs;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sel = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_res_data", 32'(res_data), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Single ADD 3+2+1, latency check
    res_ready = 1'b1;
    drive_op(2'd3, 2'd2, 1'b1, OP_ADD);
    tick();
    in_valid = 1'b0;
    chk("t1_e0_valid", 32'(res_valid), 0);
    tick();
    chk("t1_e1_valid", 32'(res_valid), 0);
    chk("t1_e1_alu_a", 32'(alu_a), 3);
    chk("t1_e1_alu_s", 32'(alu_s), 2);
    tick();
    chk("t1_e2_valid", 32'(res_valid), 1);
    chk("t1_e2_data", 32'(res_data), 6);
    chk("t1_e2_sel", 32'(res_sel), 2);
    tick();
    chk("t1_handoff_valid", 32'(res_valid), 0);
    chk("t1_op_count", 32'(op_count), 1);

    // MUL, NAND, PASS back to back
    drive_op(2'd3, 2'd3, 1'b0, OP_MUL);  tick();
    drive_op(2'd2, 2'd3, 1'b0, OP_NAND); tick();
    drive_op(2'd2, 2'd0, 1'b0, OP_PASS); tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t2_first_gap", 32'(n), 0);
    chk("t2_mul_data", 32'(res_data), 9);
    chk("t2_mul_sel", 32'(res_sel), 3);
    tick();
    wait_valid(n);
    chk("t2_nand_gap", 32'(n), 1);
    chk("t2_nand_data", 32'(res_data), 1);
    chk("t2_nand_sel", 32'(res_sel), 1);
    tick();
    wait_valid(n);
    chk("t2_pass_gap", 32'(n), 1);
    chk("t2_pass_data", 32'(res_data), 2);
    chk("t2_pass_sel", 32'(res_sel), 0);
    tick();
    chk("t2_op_count", 32'(op_count), 4);

    // Fill with consumer stalled
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      k = (acc < 5) ? acc : 4;
      drive_op(ta[k], tb[k], tc[k], ts[k]);
      if (in_ready) acc++;
      tick();
    end
    chk("t3_accepted", 32'(acc), 5);
    chk("t3_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 32'(res_valid), 1);
      chk("t3_hold_data", 32'(res_data), 2);
      chk("t3_hold_sel", 32'(res_sel), 2);
      tick();
    end

    // Drain in push order
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_valid(n);
      chk("t4_data", 32'(res_data), 32'(te[j]));
      chk("t4_sel", 32'(res_sel), 32'(ts[j]));
      tick();
      if (j == 0) chk("t4_in_ready", 32'(in_ready), 1);
    end
    chk("t4_op_count", 32'(op_count), 9);

    // Async reset mid-HOLD with three queued entries
    res_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive_op(ta[j], tb[j], tc[j], ts[j]);
      tick();
    end
    in_valid = 1'b0;
    chk("t5_pre_valid", 32'(res_valid), 1);
    rst = 1'b1;
    #1;
    chk("t5_res_valid", 32'(res_valid), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    chk("t5_op_count", 32'(op_count), 0);
    chk("t5_alu_a", 32'(alu_a), 0);
    chk("t5_alu_b", 32'(alu_b), 0);
    chk("t5_alu_cin", 32'(alu_cin), 0);
    chk("t5_alu_s", 32'(alu_s), 0);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid !== 1'b0) stale++;
    end
    chk("t5_stale_results", 32'(stale), 0);
    chk("t5_op_count_after", 32'(op_count), 0);

    // 257 ops: counter wrap and ordering
    pushed = 0;
    handed = 0;
    for (int cyc = 0; cyc < 2000 && handed < 257; cyc++) begin
      if (pushed < 257)
        drive_op(2'(pushed % 4), 2'((pushed / 4) % 4), 1'(pushed % 2), OP_ADD);
      else
        in_valid = 1'b0;
      do_push = in_valid && in_ready;
      do_hs   = res_valid && res_ready;
      if (do_hs) begin
        if (exp_q.size() > 0) chk("t6_data", 32'(res_data), 32'(exp_q.pop_front()));
        else chk("t6_unexpected_result", 32'(exp_q.size()), 1);
      end
      if (do_push) exp_q.push_back(alu_ref(in_a, in_b, in_cin, in_sel));
      tick();
      if (do_push) pushed++;
      if (do_hs) begin
        handed++;
        if (handed >= 255) chk("t6_op_count", 32'(op_count), 32'(handed % 256));
      end
    end
    in_valid = 1'b0;
    chk("t6_handed", 32'(handed), 257);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
